// File: rtl/uart_rx_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_pkg
// Types and helpers shared by the uart_rx receiver files.
//   rx_state_t : receiver FSM state encoding
//   majority3  : 2-of-3 vote used by the input noise filter
// ----------------------------------------------------------------------------
package uart_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_IDLE = 3'd4
   } rx_state_t;

   // 2-of-3 majority vote
   function automatic logic majority3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// ----------------------------------------------------------------------------
// uart_rx_sync
// Brings the asynchronous serial line into the clk domain and removes short
// noise spikes.
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset; every stage presets to 1
//                (idle line) so leaving reset never looks like a start bit
//   rxd      in  raw serial line
//   rxd_filt out registered 2-of-3 majority of the last three synced samples
// ----------------------------------------------------------------------------
module uart_rx_sync
   import uart_rx_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic rxd,
   output logic rxd_filt
);

   logic       meta_r;
   logic       sync_r;
   logic [2:0] hist_r;
   logic       filt_r;

   // Two-flop synchroniser, sample history and registered majority vote
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= 1'b1;
         sync_r <= 1'b1;
         hist_r <= 3'b111;
         filt_r <= 1'b1;
      end else begin
         meta_r <= rxd;
         sync_r <= meta_r;
         hist_r <= {hist_r[1:0], sync_r};
         filt_r <= majority3(hist_r);
      end
   end

   assign rxd_filt = filt_r;

endmodule

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// 8N1 asynchronous serial receiver, LSB first, with a single-entry byte buffer.
//   clk           in  system clock
//   resetn        in  asynchronous active-low reset
//   uart_rxd      in  serial line (idles high, asynchronous to clk)
//   uart_rx_en    in  receiver enable; low aborts any frame in progress
//   uart_rx_data  out received byte (holds its value after ack)
//   uart_rx_valid out byte buffer full
//   uart_rx_ack   in  consumer took the byte (ignored while valid is low)
//   uart_rx_break out 1-cycle pulse: all-zero frame including stop bit
//   frame_err     out 1-cycle pulse: stop bit sampled low
//   overrun       out 1-cycle pulse: byte arrived over an un-acked byte
// ----------------------------------------------------------------------------
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CLK_HZ       = 20_000_000,
   parameter int BIT_RATE     = 115_200,
   parameter int PAYLOAD_BITS = 8
)(
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    uart_rxd,
   input  logic                    uart_rx_en,
   output logic [PAYLOAD_BITS-1:0] uart_rx_data,
   output logic                    uart_rx_valid,
   input  logic                    uart_rx_ack,
   output logic                    uart_rx_break,
   output logic                    frame_err,
   output logic                    overrun
);

   localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
   localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
   localparam int CNT_W          = $clog2(CYCLES_PER_BIT);
   localparam int BIT_W          = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAYLOAD_BITS - 1);

   logic                    bit_s;
   logic                    bit_prev_r;
   logic                    fall_s;
   rx_state_t               state_r, state_nxt_s;
   logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
   logic [BIT_W-1:0]        bit_cnt_r, bit_cnt_nxt_s;
   logic [PAYLOAD_BITS-1:0] shift_r, shift_nxt_s;
   logic                    deliver_s, ferr_s, brk_s;
   logic [PAYLOAD_BITS-1:0] data_r;
   logic                    valid_r, ferr_r, brk_r, ovr_r;

   uart_rx_sync u_sync (
      .clk      (clk),
      .rst_n    (resetn),
      .rxd      (uart_rxd),
      .rxd_filt (bit_s)
   );

   // Start-bit detection works on the filtered line, not the raw pin
   assign fall_s = bit_prev_r & ~bit_s;

   // State register plus bit/cycle counters and the assembly shift register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r    <= ST_IDLE;
         cnt_r      <= {CNT_W{1'b0}};
         bit_cnt_r  <= {BIT_W{1'b0}};
         shift_r    <= {PAYLOAD_BITS{1'b0}};
         bit_prev_r <= 1'b1;
      end else begin
         state_r    <= state_nxt_s;
         cnt_r      <= cnt_nxt_s;
         bit_cnt_r  <= bit_cnt_nxt_s;
         shift_r    <= shift_nxt_s;
         bit_prev_r <= bit_s;
      end
   end

   // Next-state logic; disabling the receiver forces IDLE regardless of state
   always_comb begin
      state_nxt_s   = state_r;
      cnt_nxt_s     = cnt_r + CNT_W'(1);
      bit_cnt_nxt_s = bit_cnt_r;
      shift_nxt_s   = shift_r;
      if (!uart_rx_en) begin
         state_nxt_s   = ST_IDLE;
         cnt_nxt_s     = {CNT_W{1'b0}};
         bit_cnt_nxt_s = {BIT_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               cnt_nxt_s     = {CNT_W{1'b0}};
               bit_cnt_nxt_s = {BIT_W{1'b0}};
               if (fall_s) begin
                  state_nxt_s = ST_START;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_START: begin
               // Mid start bit: a high line means the edge was only a glitch
               if (cnt_r == CNT_HALF) begin
                  cnt_nxt_s   = {CNT_W{1'b0}};
                  state_nxt_s = bit_s ? ST_IDLE : ST_DATA;
               end else begin
                  state_nxt_s = ST_START;
               end
            end
            ST_DATA: begin
               if (cnt_r == CNT_LAST) begin
                  cnt_nxt_s   = {CNT_W{1'b0}};
                  shift_nxt_s = {bit_s, shift_r[PAYLOAD_BITS-1:1]};
                  if (bit_cnt_r == BIT_LAST) begin
                     bit_cnt_nxt_s = {BIT_W{1'b0}};
                     state_nxt_s   = ST_STOP;
                  end else begin
                     bit_cnt_nxt_s = bit_cnt_r + BIT_W'(1);
                  end
               end else begin
                  state_nxt_s = ST_DATA;
               end
            end
            ST_STOP: begin
               // Returning straight to IDLE lets the next start edge follow immediately
               if (cnt_r == CNT_LAST) begin
                  cnt_nxt_s   = {CNT_W{1'b0}};
                  state_nxt_s = bit_s ? ST_IDLE : ST_WAIT_IDLE;
               end else begin
                  state_nxt_s = ST_STOP;
               end
            end
            ST_WAIT_IDLE: begin
               // Stay here through a break so its low level is not taken as a start
               cnt_nxt_s = {CNT_W{1'b0}};
               if (bit_s) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_WAIT_IDLE;
               end
            end
            default: begin
               state_nxt_s   = ST_IDLE;
               cnt_nxt_s     = {CNT_W{1'b0}};
               bit_cnt_nxt_s = {BIT_W{1'b0}};
            end
         endcase
      end
   end

   // Stop-bit outcome decode: deliver on a high stop bit, error on a low one
   always_comb begin
      deliver_s = 1'b0;
      ferr_s    = 1'b0;
      brk_s     = 1'b0;
      if (uart_rx_en && (state_r == ST_STOP) && (cnt_r == CNT_LAST)) begin
         if (bit_s) begin
            deliver_s = 1'b1;
         end else begin
            ferr_s = 1'b1;
            brk_s  = (shift_r == {PAYLOAD_BITS{1'b0}});
         end
      end else begin
         deliver_s = 1'b0;
      end
   end

   // Byte buffer and registered status pulses
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         data_r  <= {PAYLOAD_BITS{1'b0}};
         valid_r <= 1'b0;
         ferr_r  <= 1'b0;
         brk_r   <= 1'b0;
         ovr_r   <= 1'b0;
      end else begin
         ferr_r <= ferr_s;
         brk_r  <= brk_s;
         if (deliver_s) begin
            // An ack in the same cycle frees the slot, so that case is not an overrun
            data_r  <= shift_r;
            valid_r <= 1'b1;
            ovr_r   <= valid_r & ~uart_rx_ack;
         end else begin
            ovr_r <= 1'b0;
            if (valid_r && uart_rx_ack) begin
               valid_r <= 1'b0;
            end else begin
               valid_r <= valid_r;
            end
         end
      end
   end

   assign uart_rx_data  = data_r;
   assign uart_rx_valid = valid_r;
   assign uart_rx_break = brk_r;
   assign frame_err     = ferr_r;
   assign overrun       = ovr_r;

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
// Drives uart_rx from a bit-level model of a uart_tx line and checks every
// cycle against a frame-level expectation queue plus buffer/ack rules.
// ----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int CPB    = 173;
   localparam int WIN    = 40;
   localparam int K_NONE = 0;
   localparam int K_DATA = 1;
   localparam int K_FERR = 2;
   localparam int K_BRK  = 3;

   typedef struct {
      int         kind;
      logic [7:0] data;
      longint     t;
   } exp_t;

   logic       clk = 1'b0;
   logic       resetn;
   logic       uart_rxd;
   logic       uart_rx_en;
   logic       uart_rx_ack;
   logic       ack_auto;
   logic       ack_sweep;
   logic [7:0] uart_rx_data;
   logic       uart_rx_valid;
   logic       uart_rx_break;
   logic       frame_err;
   logic       overrun;

   exp_t   exp_q[$];
   exp_t   e_m;
   int     total = 0;
   int     bad   = 0;
   longint cyc   = 0;
   int     ack_delay = -1;
   int     n_deliv = 0, n_ovr = 0, n_ferr = 0, n_brk = 0, n_coinc = 0;
   logic   v_p, a_p, fe_p, deliv, exp_ovr;
   logic [7:0] d_p;

   assign uart_rx_ack = ack_auto | ack_sweep;

   uart_rx dut (
      .clk           (clk),
      .resetn        (resetn),
      .uart_rxd      (uart_rxd),
      .uart_rx_en    (uart_rx_en),
      .uart_rx_data  (uart_rx_data),
      .uart_rx_valid (uart_rx_valid),
      .uart_rx_ack   (uart_rx_ack),
      .uart_rx_break (uart_rx_break),
      .frame_err     (frame_err),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input logic ok, input string name, input longint act, input longint expv);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Frame-level model: every delivery / error pulse must match the queue head
   initial begin : monitor
      v_p = 1'b0; a_p = 1'b0; fe_p = 1'b0; d_p = 8'h00;
      forever begin
         @(negedge clk);
         cyc++;
         if (!resetn) begin
            chk({uart_rx_valid, uart_rx_data, frame_err, uart_rx_break, overrun} == 12'h000,
                "reset_outputs", {uart_rx_valid, uart_rx_data, frame_err, uart_rx_break, overrun}, 0);
            v_p = 1'b0; a_p = 1'b0; fe_p = 1'b0; d_p = 8'h00;
            continue;
         end
         deliv   = (!v_p && uart_rx_valid) || (v_p && uart_rx_valid && (uart_rx_data != d_p)) || overrun;
         exp_ovr = deliv && v_p && !a_p;
         if (v_p && !a_p) chk(uart_rx_valid, "valid_hold", uart_rx_valid, 1);
         if (v_p && a_p && !deliv) chk(!uart_rx_valid, "ack_clear", uart_rx_valid, 0);
         if (v_p && !uart_rx_valid) chk(uart_rx_data == d_p, "data_hold_after_ack", uart_rx_data, d_p);
         chk(overrun == exp_ovr, "overrun", overrun, exp_ovr);
         if (deliv) begin
            n_deliv++;
            if (v_p && a_p) n_coinc++;
            if (overrun) n_ovr++;
            chk(exp_q.size() != 0, "unexpected_delivery", uart_rx_data, -1);
            if (exp_q.size() != 0) begin
               e_m = exp_q.pop_front();
               chk(e_m.kind == K_DATA, "delivery_kind", K_DATA, e_m.kind);
               chk(uart_rx_data == e_m.data, "rx_data", uart_rx_data, e_m.data);
               chk(cyc >= e_m.t - WIN, "delivery_early", cyc, e_m.t - WIN);
            end
         end
         if (frame_err) begin
            n_ferr++;
            if (uart_rx_break) n_brk++;
            chk(!fe_p, "frame_err_width", 2, 1);
            chk(!deliv, "err_with_delivery", deliv, 0);
            chk(exp_q.size() != 0, "unexpected_frame_err", frame_err, 0);
            if (exp_q.size() != 0) begin
               e_m = exp_q.pop_front();
               chk(e_m.kind == K_FERR || e_m.kind == K_BRK, "err_kind", K_FERR, e_m.kind);
               chk(uart_rx_break == (e_m.kind == K_BRK), "break_flag", uart_rx_break, e_m.kind == K_BRK);
               chk(cyc >= e_m.t - WIN, "err_early", cyc, e_m.t - WIN);
            end
         end else begin
            chk(!uart_rx_break, "break_without_frame_err", uart_rx_break, 0);
         end
         if (exp_q.size() != 0 && cyc > exp_q[0].t + WIN) begin
            total++;
            bad++;
            $display("FAIL event_missing: kind %0d data %0d not seen by cycle %0d", exp_q[0].kind, exp_q[0].data, cyc);
            void'(exp_q.pop_front());
         end
         v_p = uart_rx_valid; a_p = uart_rx_ack; fe_p = frame_err; d_p = uart_rx_data;
      end
   end

   // Consumer: acks ack_delay cycles after seeing valid (ack_delay < 0 = never)
   initial begin : consumer
      int c;
      ack_auto = 1'b0;
      c = 0;
      forever begin
         @(posedge clk);
         #1;
         if (ack_auto) begin
            ack_auto = 1'b0;
            c = 0;
         end else if (ack_delay >= 0 && uart_rx_valid && resetn) begin
            if (c >= ack_delay) ack_auto = 1'b1;
            else c++;
         end else begin
            c = 0;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         uart_rxd = 1'b1;
      end
   endtask

   // uart_tx line model; abort 1 = reset pulse, 2 = enable drop, during data bit 4
   task automatic send_frame(input logic [7:0] b, input int bl, input logic stop_v,
                             input int stop_bits, input int kind, input int abort, input int ack_at);
      logic [9:0] bits;
      int len;
      bits = {stop_v, b, 1'b0};
      if (kind != K_NONE) begin
         exp_t e;
         e.kind = kind;
         e.data = b;
         e.t    = cyc + 1 + (19 * CPB) / 2;
         exp_q.push_back(e);
      end
      for (int k = 0; k < 10; k++) begin
         len = (k == 9) ? stop_bits * bl : bl;
         for (int i = 0; i < len; i++) begin
            @(posedge clk);
            #1;
            uart_rxd = bits[k];
            if (abort != 0 && k == 5) begin
               if (i == bl / 2) begin
                  if (abort == 1) resetn = 1'b0;
                  else uart_rx_en = 1'b0;
               end else if (i == bl / 2 + 20) begin
                  resetn = 1'b1;
                  uart_rx_en = 1'b1;
               end
            end
            ack_sweep = (k == 9 && ack_at >= 0 && i == bl / 2 + ack_at);
         end
      end
      ack_sweep = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
      idle(40);
   endtask

   initial begin : main
      resetn = 1'b1; uart_rxd = 1'b1; uart_rx_en = 1'b1; ack_sweep = 1'b0;
      #2 resetn = 1'b0;
      repeat (5) @(posedge clk);
      #1 resetn = 1'b1;
      idle(20);

      // 1: single byte, late ack
      ack_delay = 5;
      send_frame(8'h55, CPB, 1'b1, 1, K_DATA, 0, -1);
      idle(100);
      drain();
      chk(uart_rx_data == 8'h55, "s1_data", uart_rx_data, 8'h55);
      chk(n_deliv == 1, "s1_count", n_deliv, 1);
      chk(uart_rx_valid == 1'b0, "s1_valid_after_ack", uart_rx_valid, 0);

      // 2: back-to-back frames, ack on arrival
      ack_delay = 0;
      send_frame(8'hA5, CPB, 1'b1, 1, K_DATA, 0, -1);
      send_frame(8'h3C, CPB, 1'b1, 1, K_DATA, 0, -1);
      idle(100);
      drain();
      chk(uart_rx_data == 8'h3C, "s2_data", uart_rx_data, 8'h3C);
      chk(n_deliv == 3 && n_ovr == 0, "s2_counts", n_deliv * 10 + n_ovr, 30);

      // 3: short low glitch is rejected, then a real frame
      repeat (40) begin
         @(posedge clk);
         #1;
         uart_rxd = 1'b0;
      end
      idle(300);
      send_frame(8'h81, CPB, 1'b1, 1, K_DATA, 0, -1);
      idle(100);
      drain();
      chk(uart_rx_data == 8'h81 && n_deliv == 4 && n_ferr == 0, "s3_glitch", n_deliv, 4);

      // 4: framing error, then break held three bit times
      send_frame(8'h7E, CPB, 1'b0, 1, K_FERR, 0, -1);
      idle(400);
      send_frame(8'h00, CPB, 1'b0, 3, K_BRK, 0, -1);
      idle(400);
      drain();
      chk(n_ferr == 2 && n_brk == 1, "s4_err_counts", n_ferr * 10 + n_brk, 21);
      chk(n_deliv == 4, "s4_no_delivery", n_deliv, 4);

      // 5: overrun, then sweep ack across the delivery cycle
      ack_delay = -1;
      send_frame(8'h11, CPB, 1'b1, 1, K_DATA, 0, -1);
      idle(100);
      send_frame(8'h22, CPB, 1'b1, 1, K_DATA, 0, -1);
      idle(100);
      drain();
      chk(uart_rx_data == 8'h22 && uart_rx_valid, "s5_overwrite", uart_rx_data, 8'h22);
      chk(n_ovr == 1, "s5_overrun_count", n_ovr, 1);
      for (int k = 0; k < 12; k++) begin
         send_frame(8'h30 + 8'(k), CPB, 1'b1, 1, K_DATA, 0, k);
         idle(50);
      end
      drain();
      chk(n_coinc >= 1, "s5_same_cycle_ack_seen", n_coinc, 1);
      ack_delay = 0;
      idle(50);

      // 6: reset / enable drop mid-frame, then clean frames
      send_frame(8'hF0, CPB, 1'b1, 1, K_NONE, 1, -1);
      idle(300);
      send_frame(8'h0F, CPB, 1'b1, 1, K_DATA, 0, -1);
      idle(100);
      drain();
      chk(uart_rx_data == 8'h0F, "s6_after_reset", uart_rx_data, 8'h0F);
      send_frame(8'hF0, CPB, 1'b1, 1, K_NONE, 2, -1);
      idle(300);
      send_frame(8'h0F, CPB, 1'b1, 1, K_DATA, 0, -1);
      idle(100);
      drain();
      chk(uart_rx_data == 8'h0F && n_ferr == 2, "s6_after_disable", uart_rx_data, 8'h0F);

      // bit-rate skew +/-3%
      ack_delay = 5;
      send_frame(8'h55, (CPB * 103) / 100, 1'b1, 1, K_DATA, 0, -1);
      idle(200);
      send_frame(8'h55, (CPB * 97) / 100, 1'b1, 1, K_DATA, 0, -1);
      idle(200);
      drain();

      // randomized frames, skew and ack latency
      for (int r = 0; r < 8; r++) begin
         ack_delay = $urandom_range(0, 20);
         send_frame(8'($urandom_range(0, 255)), $urandom_range(168, 178), 1'b1, 1, K_DATA, 0, -1);
         idle($urandom_range(0, 200));
      end
      idle(100);
      drain();
      chk(n_ferr == 2 && n_brk == 1, "final_err_counts", n_ferr * 10 + n_brk, 21);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
